pipeline_stage_register: RTL and testbench
==========================================

// Module: pipeline_stage_register
// PURPOSE
//  Generic, parametrised inter-stage register for the RISC-V pipeline (IF/ID, ID/EX, EX/WB). Replaces the
//  fixed-field, always-advancing stage registers with one block that carries a packed payload.
//  Adds a valid/ready handshake, back-pressure, flush and bubble insertion.
//  An optional skid entry lets in_ready be registered without losing throughput.
// PARAMETERS
//  PAYLOAD_WIDTH  64      width of packed stage payload (pc, rd, funct3/7, imm, opcode_selection, ...)
//  NOP_PAYLOAD    '0      payload driven when stage holds a bubble (opcode_selection=0 => no-op)
//  SKID           1       1: two-entry (main+skid), in_ready is a flop; 0: single entry, in_ready combinational
//  STALL_CNT_W    16      width of saturating stall-cycle counter
// PORTS
//  clk          in   1              rising-edge clock
//  rst_n        in   1              asynchronous active-low reset
//  flush        in   1              discard all held entries (branch/jump redirect)
//  in_valid     in   1              upstream stage presents payload
//  in_ready     out  1              this stage accepts payload this cycle
//  in_payload   in   PAYLOAD_WIDTH  upstream payload
//  out_valid    out  1              payload valid to downstream stage
//  out_ready    in   1              downstream accepts this cycle
//  out_payload  out  PAYLOAD_WIDTH  payload to downstream; NOP_PAYLOAD when out_valid=0
//  occupancy    out  2              entries held (0..1 if SKID=0, 0..2 if SKID=1)
//  stall_cycles out  STALL_CNT_W    cycles with out_valid&&!out_ready, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_payload=NOP_PAYLOAD, occupancy=0, stall_cycles=0,
//   in_ready=1 (SKID=1) / in_ready=1 via comb path (SKID=0), skid entry invalid.
//   Deassertion takes effect at the next clk edge; no transfer on that edge counts unless in_valid&&in_ready.
//  Transfers: accept = in_valid && in_ready; emit = out_valid && out_ready, both sampled at rising clk.
//  Latency: accepted payload appears on out_payload exactly 1 cycle later when stage was empty.
//  Ordering: strict FIFO; the skid entry is never emitted ahead of the main entry.
//  State machine (SKID=1):
//   EMPTY: accept -> FULL (main<=in).
//   FULL:  accept&&emit -> FULL (main<=in); accept&&!emit -> SKIDDED (skid<=in);
//          !accept&&emit -> EMPTY; else hold.
//   SKIDDED: in_ready=0; emit -> FULL (main<=skid); else hold.
//   in_ready registered: 1 in EMPTY/FULL, 0 in SKIDDED, i.e. computed from next state.
//  SKID=0: states EMPTY/FULL only; in_ready = !out_valid || out_ready (combinational);
//   FULL with accept&&emit replaces main in the same edge (full throughput).
//  Held payload is stable while out_valid&&!out_ready (no change to out_payload).
//  flush: at the edge, all entries invalidated -> EMPTY, out_payload=NOP_PAYLOAD, occupancy=0,
//   in_ready=1 next cycle. Flush beats a simultaneous accept (input dropped) and a simultaneous
//   emit (emit still counts downstream that cycle; the entry is not re-presented).
//  occupancy = number of valid entries after each edge; never exceeds 2 (1 if SKID=0).
//  stall_cycles: +1 per edge with out_valid&&!out_ready; holds at 2^STALL_CNT_W-1; cleared by reset only
//   (not by flush).
//  No X propagation: payload flops loaded only on accept; unused skid flops still reset to NOP_PAYLOAD.
// TESTING
//  1 Reset then in_valid=1, in_payload=0xA5, out_ready=1 -> next cycle out_valid=1, out_payload=0xA5, occupancy=1.
//  2 SKID=1: stream 0x1,0x2,0x3 with out_ready=0 from cycle 1 -> 0x1 held, 0x2 in skid, in_ready=0,
//    occupancy=2; release out_ready -> outputs 0x1,0x2,0x3 in order, nothing lost or duplicated.
//  3 Continuous in_valid=1/out_ready=1 for 100 cycles, payload=counter -> 1 emit per cycle, out = in delayed 1.
//  4 occupancy=2, assert flush with in_valid=1 payload 0x7 -> next cycle out_valid=0,
//    out_payload=NOP_PAYLOAD, occupancy=0, in_ready=1; 0x7 never emitted.
//  5 STALL_CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cycles=15 (saturated); flush keeps 15.
//  6 Drop rst_n mid-stream while occupancy=2, no clock -> outputs reach reset values immediately;
//    SKID=0 build repeats tests 1,3,4.

Source files
------------

// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: valid/ready stage register with optional skid entry, flush, bubble and stall counter
module pipeline_stage_register #(
    parameter int                       PAYLOAD_WIDTH = 64,
    parameter logic [PAYLOAD_WIDTH-1:0] NOP_PAYLOAD   = '0,
    parameter bit                       SKID          = 1'b1,
    parameter int                       STALL_CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [1:0]               occupancy,
    output logic [STALL_CNT_W-1:0]   stall_cycles
);
    typedef enum logic [1:0] {EMPTY, FULL, SKIDDED} state_t;
    state_t state, state_n;
    logic ready_q, accept, emit, load_main, load_skid, pop_skid;
    logic [PAYLOAD_WIDTH-1:0] main_q, skid_q;
    assign out_valid   = state != EMPTY;
    assign out_payload = out_valid ? main_q : NOP_PAYLOAD;
    assign occupancy   = state == SKIDDED ? 2'd2 : state == FULL ? 2'd1 : 2'd0;
    assign in_ready    = SKID ? ready_q : (!out_valid || out_ready);
    always_comb begin
        accept    = in_valid && in_ready;
        emit      = out_valid && out_ready;
        state_n   = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_n   = FULL;
                load_main = 1'b1;
            end
            FULL: if (accept && emit) begin
                load_main = 1'b1;
            end else if (accept) begin
                state_n   = SKIDDED;
                load_skid = 1'b1;
            end else if (emit) begin
                state_n = EMPTY;
            end
            SKIDDED: if (emit) begin
                state_n  = FULL;
                pop_skid = 1'b1;
            end
            default: state_n = EMPTY;
        endcase
        // flush wins over any accept or refill in the same cycle
        if (flush) state_n = EMPTY;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            ready_q      <= 1'b1;
            main_q       <= NOP_PAYLOAD;
            skid_q       <= NOP_PAYLOAD;
            stall_cycles <= '0;
        end else begin
            state   <= state_n;
            ready_q <= state_n != SKIDDED;
            if (load_main) main_q <= in_payload;
            else if (pop_skid) main_q <= skid_q;
            if (load_skid) skid_q <= in_payload;
            if (out_valid && !out_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb_pipeline_stage_register: directed vectors with a FIFO scoreboard for the SKID=1 and SKID=0 builds
module tb_pipeline_stage_register;
    logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sel = 1'b1;
    logic [15:0] in_payload = '0;
    logic r1, r0, v1, v0, o_valid, o_ready;
    logic [15:0] p1, p0, s0, o_payload, o_stall, exp_p;
    logic [3:0] s1;
    logic [1:0] c1, c0, o_occ;
    int n_cmp = 0, n_err = 0, n_acc = 0, n_emit = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    pipeline_stage_register #(.PAYLOAD_WIDTH(16), .NOP_PAYLOAD(16'hDEAD), .SKID(1'b1), .STALL_CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid && sel), .in_ready(r1),
        .in_payload(in_payload), .out_valid(v1), .out_ready(out_ready), .out_payload(p1),
        .occupancy(c1), .stall_cycles(s1));
    pipeline_stage_register #(.PAYLOAD_WIDTH(16), .NOP_PAYLOAD(16'hDEAD), .SKID(1'b0), .STALL_CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid && !sel), .in_ready(r0),
        .in_payload(in_payload), .out_valid(v0), .out_ready(out_ready), .out_payload(p0),
        .occupancy(c0), .stall_cycles(s0));

    assign o_valid   = sel ? v1 : v0;
    assign o_ready   = sel ? r1 : r0;
    assign o_payload = sel ? p1 : p0;
    assign o_occ     = sel ? c1 : c0;
    assign o_stall   = sel ? {12'b0, s1} : s0;

    // monitor: pops expected payloads on every emit, pushes on every surviving accept
    always @(negedge clk) begin
        if (!rst_n) sb.delete();
        else begin
            if (o_valid && out_ready) begin
                n_emit++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_pop: got %h expected <nothing pending>", o_payload);
                end else begin
                    exp_p = sb.pop_front();
                    if (o_payload !== exp_p) begin
                        n_err++;
                        $display("FAIL sb_payload: got %h expected %h", o_payload, exp_p);
                    end
                end
            end
            if (in_valid && o_ready && !flush) begin
                n_acc++;
                sb.push_back(in_payload);
            end
            if (flush) sb.delete();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test1();
        in_valid = 1'b1; in_payload = 16'h00A5; out_ready = 1'b1;
        tick();
        chk("t1_valid", 32'(o_valid), 32'd1);
        chk("t1_payload", 32'(o_payload), 32'h00A5);
        chk("t1_occ", 32'(o_occ), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("t1_drain_occ", 32'(o_occ), 32'd0);
    endtask

    task automatic test3();
        int a0, e0;
        a0 = n_acc; e0 = n_emit;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_payload = 16'h0100 + 16'(i);
            tick();
        end
        chk("t3_accepts", 32'(n_acc - a0), 32'd100);
        in_valid = 1'b0;
        tick();
        chk("t3_emits", 32'(n_emit - e0), 32'd100);
        chk("t3_occ", 32'(o_occ), 32'd0);
    endtask

    task automatic test4(input logic ready_at_flush);
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 16'h0011;
        tick();
        in_payload = 16'h0012;
        tick();
        chk("t4_occ_full", 32'(o_occ), sel ? 32'd2 : 32'd1);
        in_payload = 16'h0007; out_ready = ready_at_flush; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("t4_valid", 32'(o_valid), 32'd0);
        chk("t4_payload", 32'(o_payload), 32'hDEAD);
        chk("t4_occ", 32'(o_occ), 32'd0);
        chk("t4_in_ready", 32'(o_ready), 32'd1);
        if (sel) chk("t4_stall", 32'(o_stall), 32'd4);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t4_no_emit", 32'(o_valid), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_payload", 32'(o_payload), 32'hDEAD);
        chk("rst_occ", 32'(o_occ), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_in_ready", 32'(o_ready), 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        test1();
        // back-pressure into the skid entry, then release
        in_valid = 1'b1; in_payload = 16'h0001; out_ready = 1'b0;
        tick();
        in_payload = 16'h0002;
        tick();
        chk("t2_in_ready", 32'(o_ready), 32'd0);
        chk("t2_occ", 32'(o_occ), 32'd2);
        chk("t2_head", 32'(o_payload), 32'h0001);
        in_payload = 16'h0003;
        tick();
        chk("t2_hold", 32'(o_payload), 32'h0001);
        chk("t2_hold_occ", 32'(o_occ), 32'd2);
        out_ready = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        tick();
        chk("t2_empty", 32'(o_valid), 32'd0);
        chk("t2_stall", 32'(o_stall), 32'd2);
        test3();
        test4(1'b0);
        // stall counter saturation survives flush
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 16'h0055;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("t5_sat", 32'(o_stall), 32'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_keep", 32'(o_stall), 32'd15);
        chk("t5_occ", 32'(o_occ), 32'd0);
        // asynchronous reset while two entries are held
        in_valid = 1'b1; in_payload = 16'h0021;
        tick();
        in_payload = 16'h0022;
        tick();
        in_valid = 1'b0;
        chk("t6_occ", 32'(o_occ), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(o_valid), 32'd0);
        chk("t6_payload", 32'(o_payload), 32'hDEAD);
        chk("t6_occ0", 32'(o_occ), 32'd0);
        chk("t6_in_ready", 32'(o_ready), 32'd1);
        chk("t6_stall", 32'(o_stall), 32'd0);
        tick();
        sel = 1'b0;
        tick();
        rst_n = 1'b1;
        test1();
        test3();
        test4(1'b1);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
